// File: rtl/mips_pkg.sv
// Shared control types for the multicycle MIPS core: FSM states,
// opcode/funct codes and the ALU select encoding used by the ALU.
package mips_pkg;

  typedef enum logic [3:0] {
    FETCH,
    DECODE,
    MEM_ADR,
    MEM_RD,
    MEM_WB,
    MEM_WR,
    EXEC_R,
    ALU_WB,
    BRANCH,
    JUMP,
`ifdef MIPS_CTRL_IMM_EN
    IMM_EX,
    IMM_WB,
`endif
    HALT
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_NOR = 6'h27;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [3:0] ALU_AND = 4'd0;
  localparam logic [3:0] ALU_OR  = 4'd1;
  localparam logic [3:0] ALU_ADD = 4'd2;
  localparam logic [3:0] ALU_NOR = 4'd3;
  localparam logic [3:0] ALU_SLT = 4'd4;
  localparam logic [3:0] ALU_LUI = 4'd5;
  localparam logic [3:0] ALU_SUB = 4'd6;

  function automatic logic funct_ok(logic [5:0] f);
    return f == FN_ADD || f == FN_SUB || f == FN_AND ||
           f == FN_OR  || f == FN_NOR || f == FN_SLT;
  endfunction

endpackage

// File: rtl/alu_decoder.sv
// Combinational ALU select from FSM state plus funct/opcode.
// Immediate ops only decoded when MIPS_CTRL_IMM_EN is defined.
module alu_decoder
  import mips_pkg::*;
(
  input  state_t      state,
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  output logic [3:0]  alu_sel
);

`ifndef MIPS_CTRL_IMM_EN
  logic unused_opcode;
  assign unused_opcode = ^opcode;
`endif

  always_comb begin
    alu_sel = ALU_AND;
    unique case (state)
      FETCH, DECODE, MEM_ADR: alu_sel = ALU_ADD;
      BRANCH:                 alu_sel = ALU_SUB;
      EXEC_R: begin
        unique case (funct)
          FN_ADD:  alu_sel = ALU_ADD;
          FN_SUB:  alu_sel = ALU_SUB;
          FN_AND:  alu_sel = ALU_AND;
          FN_OR:   alu_sel = ALU_OR;
          FN_NOR:  alu_sel = ALU_NOR;
          FN_SLT:  alu_sel = ALU_SLT;
          default: alu_sel = ALU_AND;
        endcase
      end
`ifdef MIPS_CTRL_IMM_EN
      IMM_EX: begin
        unique case (opcode)
          OP_ADDI: alu_sel = ALU_ADD;
          OP_ORI:  alu_sel = ALU_OR;
          OP_ANDI: alu_sel = ALU_AND;
          default: alu_sel = ALU_AND;
        endcase
      end
`endif
      default: alu_sel = ALU_AND;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS main control FSM (Moore, FETCH handshakes mem_ready).
// Define MIPS_CTRL_IMM_EN to build ADDI/ANDI/ORI support.
module mips_multicycle_ctrl
  import mips_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic [3:0] alu_sel,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic [1:0] pc_source,
  output logic       illegal_op
);

  state_t state, state_n;

  // zero only qualifies the PC load inside the datapath
  logic unused_zero;
  assign unused_zero = zero;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= FETCH;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      FETCH:   if (mem_ready) state_n = DECODE;
      DECODE: begin
        unique case (opcode)
          OP_LW, OP_SW: state_n = MEM_ADR;
          OP_RTYPE:     state_n = EXEC_R;
          OP_BEQ:       state_n = BRANCH;
          OP_J:         state_n = JUMP;
`ifdef MIPS_CTRL_IMM_EN
          OP_ADDI, OP_ANDI, OP_ORI: state_n = IMM_EX;
`endif
          default:      state_n = HALT;
        endcase
      end
      MEM_ADR: state_n = (opcode == OP_SW) ? MEM_WR : MEM_RD;
      MEM_RD:  if (mem_ready) state_n = MEM_WB;
      MEM_WR:  if (mem_ready) state_n = FETCH;
      EXEC_R:  state_n = funct_ok(funct) ? ALU_WB : HALT;
`ifdef MIPS_CTRL_IMM_EN
      IMM_EX:  state_n = IMM_WB;
      IMM_WB:  state_n = FETCH;
`endif
      MEM_WB, ALU_WB, BRANCH, JUMP: state_n = FETCH;
      HALT:    state_n = HALT;
      default: state_n = FETCH;
    endcase
  end

  alu_decoder u_alu_dec (
    .state   (state),
    .opcode  (opcode),
    .funct   (funct),
    .alu_sel (alu_sel)
  );

  always_comb begin
    alu_src_a     = 1'b0;
    alu_src_b     = 2'd0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    reg_write     = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    pc_source     = 2'd0;
    illegal_op    = 1'b0;
    unique case (state)
      FETCH: begin
        mem_read  = 1'b1;
        ir_write  = mem_ready;
        alu_src_b = 2'd1;
        pc_write  = mem_ready;
      end
      DECODE:  alu_src_b = 2'd3;
      MEM_ADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'd2;
      end
      MEM_RD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
      end
      MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      MEM_WR: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
      end
      EXEC_R:  alu_src_a = 1'b1;
      ALU_WB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      BRANCH: begin
        alu_src_a     = 1'b1;
        pc_write_cond = 1'b1;
        pc_source     = 2'd1;
      end
      JUMP: begin
        pc_write  = 1'b1;
        pc_source = 2'd2;
      end
`ifdef MIPS_CTRL_IMM_EN
      IMM_EX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'd2;
      end
      IMM_WB:  reg_write = 1'b1;
`endif
      HALT:    illegal_op = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: doc/mips_multicycle_ctrl.md
MIPS_MULTICYCLE_CTRL -- requirements
Module: mips_multicycle_ctrl

Interface
REQ-001 SHALL have port: clk  input  1  rising-edge system clock.
REQ-002 SHALL have port: rst_n  input  1  reset, asynchronous and active-low.
REQ-003 SHALL have port: opcode  input  6  instruction[31:26] from IR.
REQ-004 SHALL have port: funct  input  6  instruction[5:0] from IR.
REQ-005 SHALL have port: zero  input  1  ALU zero flag.
REQ-006 SHALL have port: mem_ready  input  1  memory access complete this cycle.
REQ-007 SHALL have port: alu_sel  output  4  ALU operation select.
REQ-008 SHALL have ports: alu_src_a  output  1  0=PC, 1=reg A; alu_src_b  output  2  0=B, 1=const 4, 2=sign-ext imm, 3=sign-ext imm<<2.
REQ-009 SHALL have ports: pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write, reg_write, reg_dst, mem_to_reg  output  1 each, standard multicycle datapath enables.
REQ-010 SHALL have ports: pc_source  output  2  0=ALU, 1=ALUOut, 2=jump target; illegal_op  output  1  sticky illegal-opcode flag.

Function
REQ-011 SHALL implement a Moore FSM; all outputs are decoded from the registered state only, except pc_write_cond qualification (REQ-020).
REQ-012 States SHALL be FETCH, DECODE, MEM_ADR, MEM_RD, MEM_WB, MEM_WR, EXEC_R, ALU_WB, BRANCH, JUMP, IMM_EX, IMM_WB, HALT.
REQ-013 FETCH: mem_read=1, i_or_d=0, ir_write=mem_ready, alu_src_a=0, alu_src_b=1, alu_sel=ADD, pc_write=mem_ready; remain until mem_ready=1, then DECODE.
REQ-014 DECODE: alu_src_a=0, alu_src_b=3, alu_sel=ADD (branch target); next by opcode: LW/SW->MEM_ADR, R-type->EXEC_R, BEQ->BRANCH, J->JUMP, ADDI/ORI/ANDI->IMM_EX, else HALT.
REQ-015 MEM_ADR: alu_src_a=1, alu_src_b=2, alu_sel=ADD; LW->MEM_RD, SW->MEM_WR.
REQ-016 MEM_RD: mem_read=1, i_or_d=1; hold until mem_ready, then MEM_WB. MEM_WB: reg_write=1, reg_dst=0, mem_to_reg=1; ->FETCH.
REQ-017 MEM_WR: mem_write=1, i_or_d=1; hold until mem_ready, then FETCH.
REQ-018 EXEC_R: alu_src_a=1, alu_src_b=0, alu_sel from funct: 0x20 ADD, 0x22 SUB, 0x24 AND, 0x25 OR, 0x27 NOR, 0x2A SLT; other funct -> HALT. ALU_WB: reg_write=1, reg_dst=1, mem_to_reg=0; ->FETCH.
REQ-019 alu_sel encoding SHALL be: AND=0, OR=1, ADD=2, NOR=3, SLT=4, LUI=5, SUB=6.
REQ-020 BRANCH: alu_src_a=1, alu_src_b=0, alu_sel=SUB, pc_write_cond=1, pc_source=1; PC loads when zero=1; ->FETCH. One cycle.
REQ-021 JUMP: pc_write=1, pc_source=2; ->FETCH.
REQ-022 IMM_EX: alu_src_a=1, alu_src_b=2, alu_sel ADD/OR/AND for ADDI/ORI/ANDI; IMM_WB: reg_write=1, reg_dst=0, mem_to_reg=0; ->FETCH.
REQ-023 HALT: all enables 0, illegal_op=1; exits only via reset.
REQ-024 Any output not listed for a state SHALL be 0.
REQ-025 Latency (mem_ready=1 always): R-type 4, LW 5, SW 4, BEQ 3, J 3, imm 4 cycles.

Reset
REQ-026 rst_n=0 SHALL force state FETCH and illegal_op=0 immediately, including mid-access (MEM_RD/MEM_WR abandoned, no write completes).
REQ-027 After release, FETCH outputs (REQ-013) SHALL be driven from the first clk edge.

Configuration
REQ-028 With MIPS_CTRL_IMM_EN defined, ADDI(0x08)/ANDI(0x0C)/ORI(0x0D) SHALL use IMM_EX/IMM_WB; without it those opcodes SHALL go to HALT and IMM states are not built.

Structure
REQ-029 Package mips_pkg SHALL hold the state enum, opcode/funct constants and alu_sel encodings shared with the ALU.
REQ-030 Sub-module alu_decoder (funct/opcode+state -> alu_sel, combinational) SHALL be separate.

Verification
REQ-031 Reset, opcode=0x00 funct=0x20, mem_ready=1 -> FETCH,DECODE,EXEC_R(alu_sel=2),ALU_WB(reg_write=1,reg_dst=1),FETCH.
REQ-032 opcode=0x23, mem_ready low 3 cycles in MEM_RD -> stays MEM_RD 3 extra cycles, mem_read=1, then MEM_WB with mem_to_reg=1.
REQ-033 opcode=0x04, zero=1 then zero=0 -> pc_write_cond=1, pc_source=1 in BRANCH both times; PC loads only when zero=1.
REQ-034 opcode=0x3F -> HALT, illegal_op=1 sticky; rst_n pulse -> FETCH, illegal_op=0.
REQ-035 opcode=0x2B, rst_n asserted in MEM_WR before mem_ready -> mem_write drops to 0 asynchronously, state FETCH.
REQ-036 opcode=0x0D with/without MIPS_CTRL_IMM_EN -> IMM_EX alu_sel=1 / HALT.
